// File: rtl/phys_mem_responder.sv
// phys_mem_responder: physical main-memory model answering the victim cache's
// p_read / p_write / p_resp line interface. It stores 2^INDEX_BITS lines of
// 128 bits. Each request completes after exactly LATENCY cycles. The array is
// zeroed line by line after every reset, and init_done rises when that clear
// has finished.
module phys_mem_responder #(
    parameter int unsigned LATENCY    = 10,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         p_read,
    input  logic         p_write,
    input  logic [15:0]  p_address,
    input  logic [127:0] p_wdata,
    output logic [127:0] p_rdata,
    output logic         p_resp,
    output logic         init_done
);

    localparam int unsigned            LINES    = 1 << INDEX_BITS;
    localparam logic [7:0]             CNT_LOAD = 8'(LATENCY - 1);
    localparam logic [INDEX_BITS-1:0]  LAST_IDX = INDEX_BITS'(LINES - 1);
    localparam logic [INDEX_BITS-1:0]  IDX_ONE  = INDEX_BITS'(1);

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_BUSY_R,
        ST_BUSY_W,
        ST_DONE
    } state_t;

    // Backing store. It has no reset; the clear sweep zeroes it instead.
    logic [127:0] mem_q [LINES];

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]  clr_q, clr_d;
    logic [INDEX_BITS-1:0]  idx_q, idx_d;
    logic [127:0]           wdata_q, wdata_d;
    logic [127:0]           rdata_q, rdata_d;
    logic                   resp_q, resp_d;
    logic                   init_q, init_d;

    logic                   mem_we;
    logic [INDEX_BITS-1:0]  mem_waddr;
    logic [127:0]           mem_wline;
    logic [INDEX_BITS-1:0]  req_idx;

    // Byte offset and high address bits do not select a line. Because the
    // high bits are dropped, addresses above the array size alias onto it.
    assign req_idx = p_address[INDEX_BITS+3:4];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{p_address[15:INDEX_BITS+4], p_address[3:0]};

    assign p_rdata   = rdata_q;
    assign p_resp    = resp_q;
    assign init_done = init_q;

    // Next-state logic, output register updates and the single array write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_d     = clr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = 1'b0;
        init_d    = init_q;
        mem_we    = 1'b0;
        mem_waddr = clr_q;
        mem_wline = '0;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                clr_d     = clr_q + IDX_ONE;
                if (clr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    init_d  = 1'b1;
                end
            end

            ST_IDLE: begin
                // A write wins over a simultaneous read. The read is not remembered.
                if (p_write) begin
                    idx_d   = req_idx;
                    wdata_d = p_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY_W;
                end else if (p_read) begin
                    idx_d   = req_idx;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY_R;
                end
            end

            ST_BUSY_R: begin
                if (!p_read) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd0) begin
                    resp_d  = 1'b1;
                    rdata_d = mem_q[idx_q];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_BUSY_W: begin
                if (!p_write) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd0) begin
                    resp_d    = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = idx_q;
                    mem_wline = wdata_q;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            // The requester drops its request only after it has seen p_resp.
            // This turnaround cycle keeps that still-high request from being
            // accepted a second time.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Control and output registers, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            clr_q   <= '0;
            resp_q  <= 1'b0;
            init_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            resp_q  <= resp_d;
            init_q  <= init_d;
            rdata_q <= rdata_d;
        end
    end

    // Latched request index and write data. These are only consumed after
    // acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // Array write port. It is blocked during reset, so an operation cut short
    // by reset never reaches the array.
    always_ff @(posedge clk) begin
        if (reset_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wline;
        end
    end

endmodule

// File: tb/tb_phys_mem_responder.sv
// Bench for phys_mem_responder. It drives line requests from a vector table
// and from hand-written sequences. Every response is matched against a
// scoreboard of expected read data.
module tb_phys_mem_responder;

    localparam int LAT = 10;
    localparam int IB  = 6;
    localparam int CLEAR_CYCLES = 64;

    localparam logic [127:0] DATA_D = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [127:0] DATA_B = 128'h0BAD_F00D_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DATA_A = 128'hAAAA_5555_AAAA_5555_0F0F_F0F0_1234_5678;
    localparam logic [127:0] DATA_C = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
    localparam logic [127:0] DATA_E = 128'hEEEE_0000_EEEE_0000_EEEE_0000_EEEE_0000;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         p_read = 1'b0;
    logic         p_write = 1'b0;
    logic [15:0]  p_address = '0;
    logic [127:0] p_wdata = '0;
    logic [127:0] p_rdata;
    logic         p_resp;
    logic         init_done;

    phys_mem_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .p_read    (p_read),
        .p_write   (p_write),
        .p_address (p_address),
        .p_wdata   (p_wdata),
        .p_rdata   (p_rdata),
        .p_resp    (p_resp),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    typedef struct {
        string        name;
        logic [127:0] exp_rdata;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  mon_e;
    int   resp_count = 0;
    logic prev_resp = 1'b0;

    // Response monitor: pulse width, no unexpected responses, read data.
    always @(negedge clk) begin
        if (p_resp === 1'b1) begin
            resp_count++;
            check("resp_single_cycle", prev_resp, 1'b0);
            check("resp_expected", (sb_q.size() != 0), 1'b1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_rdata"}, p_rdata, mon_e.exp_rdata);
            end
        end
        prev_resp = p_resp;
    end

    // Issues one request and returns at a negedge with the DUT back in idle.
    // The caller must already be positioned at a negedge.
    task automatic do_req(input string name, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [127:0] data,
                          input logic [127:0] exp_rdata, input bit hold_extra);
        int  lat;
        sb_t e;
        e.name      = name;
        e.exp_rdata = exp_rdata;
        sb_q.push_back(e);
        p_read    = rd;
        p_write   = wr;
        p_address = addr;
        p_wdata   = data;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (p_resp !== 1'b1 && lat < 300);
        check({name, "_latency"}, lat, LAT);
        if (lat >= 300 && sb_q.size() != 0) void'(sb_q.pop_back());
        if (!hold_extra) begin
            p_read  = 1'b0;
            p_write = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        p_read  = 1'b0;
        p_write = 1'b0;
    endtask

    // Counts cycles from reset release until init_done rises (bounded).
    task automatic wait_init(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (init_done !== 1'b1 && n < 300);
    endtask

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        int rc;

        vecs[0] = '{"wr_0123",    1'b0, 1'b1, 16'h0123, DATA_D, 128'h0};
        vecs[1] = '{"rd_0123",    1'b1, 1'b0, 16'h0123, 128'h0, DATA_D};
        vecs[2] = '{"rd_03F0",    1'b1, 1'b0, 16'h03F0, 128'h0, 128'h0};
        vecs[3] = '{"wr_0000",    1'b0, 1'b1, 16'h0000, DATA_B, 128'h0};
        vecs[4] = '{"rd_0400",    1'b1, 1'b0, 16'h0400, 128'h0, DATA_B};
        vecs[5] = '{"rw_0050",    1'b1, 1'b1, 16'h0050, DATA_A, DATA_B};
        vecs[6] = '{"rd_0050",    1'b1, 1'b0, 16'h0050, 128'h0, DATA_A};

        // Reset held two cycles with a read pending, then the clear sweep.
        reset_n = 1'b0;
        p_read  = 1'b1;
        p_address = 16'h0123;
        @(negedge clk);
        repeat (2) @(negedge clk);
        check("rst_resp", p_resp, 1'b0);
        check("rst_rdata", p_rdata, 128'h0);
        check("rst_init_done", init_done, 1'b0);
        reset_n = 1'b1;
        wait_init(n);
        p_read = 1'b0;
        check("clear_cycles", n, CLEAR_CYCLES);
        check("clear_no_resp", resp_count, 0);

        // Table-driven transactions, each followed by a p_rdata hold check.
        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata, 1'b0);
            repeat (2) @(negedge clk);
            check({vecs[i].name, "_hold"}, p_rdata, vecs[i].exp_rdata);
        end

        // Write aborted after 4 cycles, then a read accepted on the next cycle.
        rc = resp_count;
        p_write   = 1'b1;
        p_address = 16'h0050;
        p_wdata   = DATA_C;
        repeat (4) @(posedge clk);
        @(negedge clk);
        p_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_no_resp", resp_count - rc, 0);
        do_req("rd_after_abort", 1'b1, 1'b0, 16'h0050, 128'h0, DATA_A, 1'b0);

        // Read held one cycle past p_resp must not start a second operation.
        rc = resp_count;
        do_req("rd_hold_past_resp", 1'b1, 1'b0, 16'h0123, 128'h0, DATA_D, 1'b1);
        repeat (2 * LAT + 5) @(negedge clk);
        check("no_reaccept", resp_count - rc, 1);

        // Reset pulsed in the middle of a write.
        rc = resp_count;
        p_write   = 1'b1;
        p_address = 16'h0010;
        p_wdata   = DATA_E;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        p_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_init_done", init_done, 1'b0);
        check("midrst_rdata", p_rdata, 128'h0);
        reset_n = 1'b1;
        wait_init(n);
        check("midrst_clear_cycles", n, CLEAR_CYCLES);
        check("midrst_no_resp", resp_count - rc, 0);
        do_req("rd_0010_after_rst", 1'b1, 1'b0, 16'h0010, 128'h0, 128'h0, 1'b0);
        do_req("rd_0123_cleared", 1'b1, 1'b0, 16'h0123, 128'h0, 128'h0, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/phys_mem_responder.md
Name: phys_mem_responder

Overview:
- Behavioural-synthesizable model of main (physical) memory: the responder end of the p_read / p_write / p_resp line interface driven by the victim cache controller.
- Serves 128-bit line reads and writes after a fixed, parameterized latency.
- Clears its backing array after reset.
- Sits below the victim cache in the lc3b memory hierarchy; used in simulation and FPGA bring-up in place of the external memory model.

Parameters:
- LATENCY, 10, cycles from request acceptance to p_resp; legal range 1..255.
- INDEX_BITS, 6, log2 of number of stored lines (default 64 lines = 1 KB).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- p_read  input  1  line read request, held high until p_resp
- p_write  input  1  line write request, held high until p_resp
- p_address  input  16  byte address; bits [3:0] ignored; line index = p_address[INDEX_BITS+3:4]
- p_wdata  input  128  write line data, valid while p_write high
- p_rdata  output  128  read line data
- p_resp  output  1  one-cycle completion pulse
- init_done  output  1  high once post-reset clear has finished

Behaviour:
- Reset: when reset_n is low at a clock edge:
  - p_resp=0, p_rdata=0, init_done=0, counter=0, clear index=0.
  - FSM goes to st_clear.
  - Any operation in progress is abandoned with no resp and no array write.
- st_clear:
  - Writes 128'h0 to line[clear index] each cycle and increments the index.
  - After line 2^INDEX_BITS-1 is written, goes to st_idle and sets init_done=1; clearing therefore takes exactly 2^INDEX_BITS cycles.
  - Requests are ignored; p_resp stays 0.
- st_idle:
  - On p_write: latch index and p_wdata, load counter=LATENCY-1, go to st_busy_w.
  - Else on p_read: latch index, load counter, go to st_busy_r.
  - p_write has priority if both are asserted; the read is dropped and is not queued.
- st_busy_r / st_busy_w:
  - Decrement the counter each cycle.
  - If the active request (p_read for a read, p_write for a write) is sampled low before completion, abort: return to st_idle, no resp, no array change.
  - When counter==0 and the request is still high, the resp cycle follows:
    - Next edge: p_resp=1 for exactly one cycle.
    - Read: p_rdata is loaded with line[latched index] in the same edge.
    - Write: line[latched index] is written with the latched p_wdata in the same edge.
    - FSM goes to st_done.
- Request to p_resp latency is exactly LATENCY cycles:
  - Request sampled high at edge E0.
  - p_resp high during the cycle after edge E0+LATENCY.
- st_done:
  - One turnaround cycle; requests are ignored and p_resp=0. This prevents the still-asserted request from being re-accepted.
  - Goes to st_idle.
- p_rdata holds its last read value until the next read completes; writes and aborts do not change it.
- Address bits above INDEX_BITS+3 are ignored (aliasing wrap-around).
- Read-after-write to the same line returns the new data.
- Counter is 8 bits, with no wrap; LATENCY=1 gives p_resp in the cycle right after acceptance.

Test Plan:
1. Reset with INDEX_BITS=6: hold reset_n=0 two cycles, release -> init_done rises exactly 64 cycles later; p_resp stays 0 throughout, even with p_read held high during the clear.
2. LATENCY=10: p_write address 16'h0123, data 128'hDEAD...BEEF, held until resp -> p_resp a single-cycle pulse 10 cycles after acceptance. Then p_read same address -> p_rdata = DEAD...BEEF in the resp cycle and held afterwards.
3. Read of never-written line 16'h03F0 after init -> p_rdata=0 with resp at latency 10. Read 16'h0400 after writing 16'h0000 -> returns the aliased data.
4. p_read and p_write asserted together at address 16'h0050 with data A -> write performed, one p_resp only, no read-data change. A later read returns A.
5. p_write asserted, then dropped after 4 cycles -> no p_resp, target line unchanged. A new p_read is accepted the next cycle, with full latency.
6. Requester keeps p_read high one cycle past p_resp -> no second operation is started (st_done turnaround). reset_n pulsed mid-st_busy_w -> no resp, line not written, init_done drops and the clear restarts.
